// File: rtl/mac_array_pkg.sv
// Shared definitions for the mac array west-edge issuer: tile instruction
// encodings, command op codes, issuer FSM states and the op-to-instruction map.
package mac_array_pkg;

    localparam logic [2:0] INST_NOP      = 3'b000;
    localparam logic [2:0] INST_WS_LOAD  = 3'b001;
    localparam logic [2:0] INST_WS_EXEC  = 3'b010;
    localparam logic [2:0] INST_OS_EXEC  = 3'b110;
    localparam logic [2:0] INST_OS_FLUSH = 3'b101;

    typedef enum logic [1:0] {
        OP_WS_LOAD  = 2'b00,
        OP_WS_EXEC  = 2'b01,
        OP_OS_EXEC  = 2'b10,
        OP_OS_FLUSH = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        DRAIN = 2'b10
    } issuer_state_e;

    // Instruction carried by a real (non-bubble) beat of the given op.
    function automatic logic [2:0] head_inst(input op_e op);
        logic [2:0] inst;
        case (op)
            OP_WS_LOAD:  inst = INST_WS_LOAD;
            OP_WS_EXEC:  inst = INST_WS_EXEC;
            OP_OS_EXEC:  inst = INST_OS_EXEC;
            OP_OS_FLUSH: inst = INST_OS_FLUSH;
            default:     inst = INST_NOP;
        endcase
        return inst;
    endfunction

endpackage

// File: rtl/issue_skew_line.sv
// Per-row delay line: a plain shift register of {data, inst} for one row.
// Row r uses depth r+1 so its beats trail row 0 by r cycles.
module issue_skew_line #(
    parameter int width = 7,
    parameter int depth = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    logic [width-1:0] stg [depth];

    // Shift the head value down the line every cycle; reset clears every stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < depth; i++) stg[i] <= '0;
        end else begin
            stg[0] <= d;
            for (int i = 1; i < depth; i++) stg[i] <= stg[i-1];
        end
    end

    assign q = stg[depth-1];

endmodule

// File: rtl/mac_west_issuer.sv
// West-edge issuer for a row of mac_tile PEs. Accepts one command at a time,
// issues cmd_len beats (stream data for WS/OS ops, zero data for OS flush),
// then drains row-1 bubbles so the tail reaches the last row before done.
// Optional build macro ISSUER_STALL_CNT_EN adds the stall_cnt bubble counter.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// ISSUE | issuing beats; counter counts down from cmd_len
// DRAIN | head issues bubbles for row-1 cycles
module mac_west_issuer
    import mac_array_pkg::*;
#(
    parameter int bw     = 4,
    parameter int row    = 8,
    parameter int len_bw = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [len_bw-1:0] cmd_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [row*bw-1:0] in_data,
    output logic [row*bw-1:0] out_w,
    output logic [row*3-1:0]  inst_w,
`ifdef ISSUER_STALL_CNT_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic              busy,
    output logic              done
);

    localparam int DCW = (row > 1) ? $clog2(row) : 1;
    localparam logic [DCW-1:0] DRAIN_LEN = DCW'(row - 1);

    issuer_state_e     state, state_nxt;
    op_e               op_q, op_nxt;
    logic [len_bw-1:0] beat_cnt, beat_cnt_nxt;
    logic [DCW-1:0]    drain_cnt, drain_cnt_nxt;
    logic              done_nxt;
    logic              cmd_acc;
    logic              flush_op;
    logic              fire;
    logic [row*bw-1:0] head_data;
    logic [2:0]        head_ins;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign flush_op  = (op_q == OP_OS_FLUSH);
    assign in_ready  = (state == ISSUE) && !flush_op;
    // Flush beats never stall; data ops issue only on a handshake.
    assign fire      = (state == ISSUE) && (flush_op || in_valid);
    assign head_ins  = fire ? head_inst(op_q) : INST_NOP;
    assign head_data = (fire && !flush_op) ? in_data : '0;

    // FSM state, latched command and down-counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            op_q      <= OP_WS_LOAD;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            op_q      <= op_nxt;
            beat_cnt  <= beat_cnt_nxt;
            drain_cnt <= drain_cnt_nxt;
            done      <= done_nxt;
        end
    end

    // Next-state: beat count terminates at 1, drain count terminates at 1.
    always_comb begin
        state_nxt     = state;
        op_nxt        = op_q;
        beat_cnt_nxt  = beat_cnt;
        drain_cnt_nxt = drain_cnt;
        done_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_acc) begin
                    op_nxt       = op_e'(cmd_op);
                    beat_cnt_nxt = cmd_len;
                    if (cmd_len != '0) begin
                        state_nxt = ISSUE;
                    end else if (row > 1) begin
                        state_nxt     = DRAIN;
                        drain_cnt_nxt = DRAIN_LEN;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (fire) begin
                    beat_cnt_nxt = beat_cnt - 1'b1;
                    if (beat_cnt == len_bw'(1)) begin
                        if (row > 1) begin
                            state_nxt     = DRAIN;
                            drain_cnt_nxt = DRAIN_LEN;
                        end else begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end
                    end
                end
            end
            DRAIN: begin
                drain_cnt_nxt = drain_cnt - 1'b1;
                if (drain_cnt <= DCW'(1)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef ISSUER_STALL_CNT_EN
    // Count input-starved bubbles of the current command, saturating.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (cmd_acc) begin
            stall_cnt <= '0;
        end else if ((state == ISSUE) && !flush_op && !in_valid && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

    for (genvar r = 0; r < row; r++) begin : g_row
        logic [bw+2:0] line_q;

        issue_skew_line #(
            .width (bw + 3),
            .depth (r + 1)
        ) u_line (
            .clk     (clk),
            .reset_n (reset_n),
            .d       ({head_data[r*bw +: bw], head_ins}),
            .q       (line_q)
        );

        assign out_w[r*bw +: bw] = line_q[bw+2:3];
        assign inst_w[r*3 +: 3]  = line_q[2:0];
    end

endmodule
